// File: rtl/bp_table_scheduler.sv
// bp_table_scheduler: arbitrates one single-ported 2-bit counter table between
// fetch lookups and retire training updates. The table is cleared after reset,
// updates are queued in a small FIFO, and one FSM sequences every access.
// Optional: define BP_UPD_PRIO_EN to let a full FIFO drain ahead of lookups.
module bp_table_scheduler #(
  parameter int          IDX_W      = 10,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [1:0]  INIT_VAL   = 2'b00,
  localparam int         PW         = $clog2(FIFO_DEPTH),
  localparam int         CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             pred_valid_i,
  input  logic [IDX_W-1:0] pred_idx_i,
  output logic             pred_ready_o,
  output logic             pred_resp_valid_o,
  output logic             pred_taken_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_outcome_i,
  output logic             upd_ready_o,
  output logic             tbl_en_o,
  output logic             tbl_we_o,
  output logic [IDX_W-1:0] tbl_addr_o,
  output logic [1:0]       tbl_wdata_o,
  input  logic [1:0]       tbl_rdata_i,
  output logic             init_done_o,
  output logic [CW-1:0]    fifo_count_o
);

  typedef enum logic [2:0] {INIT, IDLE, PRED_RSP, UPD_RD, UPD_WR} state_t;

  state_t             state_q;
  logic               wr_en_q;      // registered write strobe (INIT and UPD_WR)
  logic [IDX_W-1:0]   wr_addr_q;    // doubles as the init pointer
  logic [1:0]         wr_data_q;    // holds the trained counter between UPD_RD and UPD_WR
  logic               init_done_q;

  logic [IDX_W-1:0]   fifo_idx_q [FIFO_DEPTH];
  logic               fifo_out_q [FIFO_DEPTH];
  logic [PW-1:0]      wp_q, rp_q;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic full, empty, drain_first, idle, pred_acc, drain_go, rd_en, push, pop;
  logic [IDX_W-1:0] head_idx;
  logic             head_out;

  // Hysteresis counter: taken 00->01->11, 10->11; not taken 11->10, else ->00.
  function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic t);
    logic [1:0] n;
    n = 2'b00;
    if (t) n = (c == 2'b00) ? 2'b01 : 2'b11;
    else   n = (c == 2'b11) ? 2'b10 : 2'b00;
    return n;
  endfunction

  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign head_idx = fifo_idx_q[rp_q];
  assign head_out = fifo_out_q[rp_q];
  assign idle     = (state_q == IDLE);

`ifdef BP_UPD_PRIO_EN
  assign drain_first = full;
`else
  assign drain_first = 1'b0;
`endif

  assign pred_ready_o      = idle && !drain_first;
  assign pred_acc          = pred_ready_o && pred_valid_i;
  assign drain_go          = idle && !empty && !pred_acc;
  assign rd_en             = pred_acc || drain_go;

  // Reads are issued combinationally from IDLE; writes come from registers so
  // reset kills them immediately.
  assign tbl_en_o          = wr_en_q || rd_en;
  assign tbl_we_o          = wr_en_q;
  assign tbl_addr_o        = wr_en_q ? wr_addr_q : (pred_acc ? pred_idx_i : (drain_go ? head_idx : '0));
  assign tbl_wdata_o       = wr_data_q;

  assign pred_resp_valid_o = (state_q == PRED_RSP);
  assign pred_taken_o      = pred_resp_valid_o && tbl_rdata_i[1];
  assign init_done_o       = init_done_q;
  assign upd_ready_o       = init_done_q && !full;
  assign fifo_count_o      = cnt_q;

  assign push  = upd_valid_i && upd_ready_o;
  assign pop   = (state_q == UPD_WR);
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  // Table access sequencer: clear, arbitrate, lookup response, read-modify-write.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= INIT;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 2'b00;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (!wr_en_q) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= INIT_VAL;
          end else if (wr_addr_q != '1) begin
            wr_addr_q <= wr_addr_q + 1'b1;
          end else begin
            wr_en_q     <= 1'b0;
            init_done_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        IDLE: begin
          if (pred_acc)      state_q <= PRED_RSP;
          else if (drain_go) state_q <= UPD_RD;
        end
        PRED_RSP: state_q <= IDLE;
        UPD_RD: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= head_idx;
          wr_data_q <= next_ctr(tbl_rdata_i, head_out);
          state_q   <= UPD_WR;
        end
        UPD_WR: begin
          wr_en_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Update FIFO pointers and occupancy.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Update FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clock_i) begin
    if (push) begin
      fifo_idx_q[wp_q] <= upd_idx_i;
      fifo_out_q[wp_q] <= upd_outcome_i;
    end
  end

endmodule

// File: tb/tb_bp_table_scheduler.sv
// Bench for bp_table_scheduler with IDX_W=4: table-driven lookup/training
// vectors plus directed sequences for init, backpressure, push+pop and reset.
module tb_bp_table_scheduler;
  localparam int IW = 4;

  logic          clock_i = 1'b0, reset_i = 1'b1;
  logic          pred_valid_i = 1'b0, upd_valid_i = 1'b0, upd_outcome_i = 1'b0;
  logic [IW-1:0] pred_idx_i = '0, upd_idx_i = '0;
  logic          pred_ready_o, pred_resp_valid_o, pred_taken_o, upd_ready_o;
  logic          tbl_en_o, tbl_we_o, init_done_o;
  logic [IW-1:0] tbl_addr_o;
  logic [1:0]    tbl_wdata_o, tbl_rdata_i;
  logic [2:0]    fifo_count_o;

  bp_table_scheduler #(.IDX_W(IW), .FIFO_DEPTH(4), .INIT_VAL(2'b00)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .pred_valid_i(pred_valid_i), .pred_idx_i(pred_idx_i), .pred_ready_o(pred_ready_o),
    .pred_resp_valid_o(pred_resp_valid_o), .pred_taken_o(pred_taken_o),
    .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i), .upd_outcome_i(upd_outcome_i),
    .upd_ready_o(upd_ready_o), .tbl_en_o(tbl_en_o), .tbl_we_o(tbl_we_o),
    .tbl_addr_o(tbl_addr_o), .tbl_wdata_o(tbl_wdata_o), .tbl_rdata_i(tbl_rdata_i),
    .init_done_o(init_done_o), .fifo_count_o(fifo_count_o));

  always #5 clock_i = ~clock_i;

  // Table model with a write log; garbage-filled while reset is high.
  logic [1:0]    mem [16];
  logic [IW-1:0] wa [256];
  logic [1:0]    wd [256];
  int            wr_n = 0;
  always @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < 16; i++) mem[i] <= 2'b11;
    end else if (tbl_en_o) begin
      if (tbl_we_o) begin
        mem[tbl_addr_o] <= tbl_wdata_o;
        if (wr_n < 256) begin
          wa[wr_n] <= tbl_addr_o;
          wd[wr_n] <= tbl_wdata_o;
        end
        wr_n <= wr_n + 1;
      end else begin
        tbl_rdata_i <= mem[tbl_addr_o];
      end
    end
  end

  int total = 0, pass = 0;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic cyc();
    @(negedge clock_i); #1;
  endtask

  // Called at reset release: expects 16 writes of 00 to 0..15, then init_done.
  task automatic wait_init(input string tg);
    int m, n;
    m = wr_n; n = 0;
    while (!init_done_o && n < 40) begin
      cyc();
      if (!init_done_o) begin
        chk({tg, "_prdy_in_init"}, int'(pred_ready_o), 0);
        chk({tg, "_urdy_in_init"}, int'(upd_ready_o), 0);
      end
      n++;
    end
    chk({tg, "_init_done"}, int'(init_done_o), 1);
    chk({tg, "_init_writes"}, wr_n - m, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_init_addr%0d", tg, i), int'(wa[m+i]), i);
      chk($sformatf("%s_init_data%0d", tg, i), int'(wd[m+i]), 0);
    end
    chk({tg, "_prdy_after_init"}, int'(pred_ready_o), 1);
  endtask

  task automatic wait_empty(input string tg);
    int n;
    n = 0;
    while (fifo_count_o != 0 && n < 40) begin cyc(); n++; end
    chk({tg, "_drain_timeout"}, int'(fifo_count_o != 0), 0);
    cyc(); cyc();
  endtask

  typedef struct {
    logic pv; logic [3:0] pidx; logic uv; logic [3:0] uidx; logic uo;
    logic en; logic we; logic [3:0] addr; logic [1:0] wdat;
    logic prdy; logic urdy; logic rv; logic tk; int cnt;
  } vec_t;

  function automatic vec_t mk(logic pv, logic [3:0] pidx, logic uv, logic [3:0] uidx, logic uo,
                              logic en, logic we, logic [3:0] addr, logic [1:0] wdat,
                              logic prdy, logic urdy, logic rv, logic tk, int cnt);
    vec_t v;
    v.pv = pv; v.pidx = pidx; v.uv = uv; v.uidx = uidx; v.uo = uo;
    v.en = en; v.we = we; v.addr = addr; v.wdat = wdat;
    v.prdy = prdy; v.urdy = urdy; v.rv = rv; v.tk = tk; v.cnt = cnt;
    return v;
  endfunction

  vec_t       vt [27];
  logic       t_out [4];
  logic [1:0] t_wd  [4];
  logic       t_tk  [4];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m, pushed;
    logic found;

    // Lookup of idx 5 after init, then four training steps on idx 5.
    t_out[0] = 1'b1; t_wd[0] = 2'b01; t_tk[0] = 1'b0;
    t_out[1] = 1'b1; t_wd[1] = 2'b11; t_tk[1] = 1'b1;
    t_out[2] = 1'b0; t_wd[2] = 2'b10; t_tk[2] = 1'b1;
    t_out[3] = 1'b0; t_wd[3] = 2'b00; t_tk[3] = 1'b0;
    //          pv idx uv uidx uo  en we addr wd  prdy urdy rv tk cnt
    vt[0] = mk(1, 5, 0, 0, 0,   1, 0, 5, 0,   1, 1, 0, 0, 0);
    vt[1] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 1, 1, 0, 0);
    vt[2] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0,   1, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      vt[3+6*k] = mk(0, 0, 1, 5, t_out[k], 0, 0, 0, 0,       1, 1, 0, 0,       0);
      vt[4+6*k] = mk(0, 0, 0, 0, 0,        1, 0, 5, 0,       1, 1, 0, 0,       1);
      vt[5+6*k] = mk(0, 0, 0, 0, 0,        0, 0, 0, 0,       0, 1, 0, 0,       1);
      vt[6+6*k] = mk(0, 0, 0, 0, 0,        1, 1, 5, t_wd[k], 0, 1, 0, 0,       1);
      vt[7+6*k] = mk(1, 5, 0, 0, 0,        1, 0, 5, 0,       1, 1, 0, 0,       0);
      vt[8+6*k] = mk(0, 0, 0, 0, 0,        0, 0, 0, 0,       0, 1, 1, t_tk[k], 0);
    end

    // Reset values.
    #2;
    chk("rst_tbl_en", int'(tbl_en_o), 0);
    chk("rst_tbl_we", int'(tbl_we_o), 0);
    chk("rst_tbl_addr", int'(tbl_addr_o), 0);
    chk("rst_tbl_wdata", int'(tbl_wdata_o), 0);
    chk("rst_prdy", int'(pred_ready_o), 0);
    chk("rst_urdy", int'(upd_ready_o), 0);
    chk("rst_rv", int'(pred_resp_valid_o), 0);
    chk("rst_tk", int'(pred_taken_o), 0);
    chk("rst_init_done", int'(init_done_o), 0);
    chk("rst_cnt", int'(fifo_count_o), 0);
    @(negedge clock_i); @(negedge clock_i);
    reset_i = 1'b0;
    wait_init("i0");

    // Table-driven lookup and training.
    for (int i = 0; i < 27; i++) begin
      @(negedge clock_i);
      pred_valid_i = vt[i].pv; pred_idx_i = vt[i].pidx;
      upd_valid_i = vt[i].uv; upd_idx_i = vt[i].uidx; upd_outcome_i = vt[i].uo;
      #1;
      chk($sformatf("v%0d_en", i), int'(tbl_en_o), int'(vt[i].en));
      if (vt[i].en) begin
        chk($sformatf("v%0d_we", i), int'(tbl_we_o), int'(vt[i].we));
        chk($sformatf("v%0d_addr", i), int'(tbl_addr_o), int'(vt[i].addr));
      end
      if (vt[i].we) chk($sformatf("v%0d_wdata", i), int'(tbl_wdata_o), int'(vt[i].wdat));
      chk($sformatf("v%0d_prdy", i), int'(pred_ready_o), int'(vt[i].prdy));
      chk($sformatf("v%0d_urdy", i), int'(upd_ready_o), int'(vt[i].urdy));
      chk($sformatf("v%0d_rv", i), int'(pred_resp_valid_o), int'(vt[i].rv));
      if (vt[i].rv) chk($sformatf("v%0d_tk", i), int'(pred_taken_o), int'(vt[i].tk));
      chk($sformatf("v%0d_cnt", i), int'(fifo_count_o), vt[i].cnt);
    end
    @(negedge clock_i);
    pred_valid_i = 0; upd_valid_i = 0;

    // Starvation: continuous lookups while 5 updates are offered to idx 10..14.
    m = wr_n; pushed = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock_i);
      pred_valid_i = 1; pred_idx_i = 3;
      upd_valid_i = (pushed < 5); upd_idx_i = 4'(10 + pushed); upd_outcome_i = 1;
      #1;
`ifndef BP_UPD_PRIO_EN
      chk($sformatf("st%0d_urdy", c), int'(upd_ready_o), int'(pushed < 4));
      chk($sformatf("st%0d_cnt", c), int'(fifo_count_o), pushed);
      chk($sformatf("st%0d_we", c), int'(tbl_we_o), 0);
`endif
      if (upd_valid_i && upd_ready_o) pushed++;
    end
`ifndef BP_UPD_PRIO_EN
    chk("st_pushed", pushed, 4);
    chk("st_full_cnt", int'(fifo_count_o), 4);
    chk("st_no_writes", wr_n - m, 0);
`else
    chk("st_prio_drain", int'(wr_n - m > 0), 1);
`endif
    @(negedge clock_i);
    pred_valid_i = 0; upd_valid_i = 0;
    #1;
    wait_empty("st");
    if (pushed < 5) begin
      @(negedge clock_i);
      upd_valid_i = 1; upd_idx_i = 4'(10 + pushed); upd_outcome_i = 1;
      #1;
      chk("st_fifth_urdy", int'(upd_ready_o), 1);
      @(negedge clock_i);
      upd_valid_i = 0;
      #1;
      wait_empty("st5");
    end
    chk("st_total_writes", wr_n - m, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("st_waddr%0d", i), int'(wa[m+i]), 10 + i);
      chk($sformatf("st_wdata%0d", i), int'(wd[m+i]), 1);
    end

    // Push and pop in the same cycle at fifo_count=2.
    m = wr_n;
    @(negedge clock_i); upd_valid_i = 1; upd_idx_i = 7; upd_outcome_i = 1; #1;
    chk("pp0_en", int'(tbl_en_o), 0);
    chk("pp0_cnt", int'(fifo_count_o), 0);
    @(negedge clock_i); upd_idx_i = 8; #1;
    chk("pp1_en", int'(tbl_en_o), 1);
    chk("pp1_addr", int'(tbl_addr_o), 7);
    chk("pp1_cnt", int'(fifo_count_o), 1);
    @(negedge clock_i); upd_valid_i = 0; #1;
    chk("pp2_en", int'(tbl_en_o), 0);
    chk("pp2_cnt", int'(fifo_count_o), 2);
    @(negedge clock_i); upd_valid_i = 1; upd_idx_i = 9; #1;
    chk("pp3_we", int'(tbl_we_o), 1);
    chk("pp3_addr", int'(tbl_addr_o), 7);
    chk("pp3_wdata", int'(tbl_wdata_o), 1);
    chk("pp3_urdy", int'(upd_ready_o), 1);
    chk("pp3_cnt", int'(fifo_count_o), 2);
    @(negedge clock_i); upd_valid_i = 0; #1;
    chk("pp4_cnt", int'(fifo_count_o), 2);
    wait_empty("pp");
    chk("pp_writes", wr_n - m, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pp_waddr%0d", i), int'(wa[m+i]), 7 + i);
      chk($sformatf("pp_wdata%0d", i), int'(wd[m+i]), 1);
    end

    // Reset asserted during UPD_WR.
    @(negedge clock_i); upd_valid_i = 1; upd_idx_i = 6; upd_outcome_i = 1;
    @(negedge clock_i);
    @(negedge clock_i); upd_valid_i = 0;
    #1;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (tbl_we_o) found = 1'b1;
      else cyc();
    end
    chk("rw_found_upd_wr", int'(found), 1);
    chk("rw_cnt_before", int'(fifo_count_o), 2);
    reset_i = 1'b1;
    #1;
    chk("rw_tbl_en", int'(tbl_en_o), 0);
    chk("rw_tbl_we", int'(tbl_we_o), 0);
    chk("rw_cnt", int'(fifo_count_o), 0);
    chk("rw_init_done", int'(init_done_o), 0);
    chk("rw_urdy", int'(upd_ready_o), 0);
    @(negedge clock_i); @(negedge clock_i);
    reset_i = 1'b0;
    wait_init("i1");
    chk("rw_cnt_after", int'(fifo_count_o), 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
